// File: rtl/lstm_state_buf_pkg.sv
// Shared definitions for the LSTM timestep state buffer: default word geometry
// and the forward/backward sequencing states.
package lstm_state_buf_pkg;

  localparam int WIDTH_DEF = 24;
  localparam int FRAC_DEF  = 20;
  localparam int DEPTH_DEF = 8;

  // Fields stored per timestep, packed as {a, i, f, o, c, h} (h in the low word).
  localparam int N_FIELDS = 6;
  localparam int C_FIELD  = 1;

  typedef enum logic [1:0] {
    FWD  = 2'd0,
    BWD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lstm_state_buf_ts_mem.sv
// Timestep store: DEPTH words of six packed cell outputs, one write port, one
// registered read port, plus a combinational tap on the c field for cprev.
module ts_mem
  import lstm_state_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [ADDR-1:0]           wr_addr,
  input  logic [N_FIELDS*WIDTH-1:0] wr_data,
  input  logic                      rd_en,
  input  logic [ADDR-1:0]           rd_addr,
  output logic [N_FIELDS*WIDTH-1:0] rd_data,
  input  logic [ADDR-1:0]           tap_addr,
  output logic [WIDTH-1:0]          tap_c
);

  logic [N_FIELDS*WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; validity is tracked by the
  // owner's count, and leaving it unreset lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst)       rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

  assign tap_c = mem[tap_addr][C_FIELD*WIDTH +: WIDTH];

endmodule

// File: rtl/lstm_state_buf.sv
// LSTM state buffer: feeds c(t-1)/h(t-1) back to the cell during the forward
// pass, then replays stored timesteps newest-first for backpropagation.
module lstm_state_buf
  import lstm_state_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_wr_en,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_i,
  input  logic signed [WIDTH-1:0] i_f,
  input  logic signed [WIDTH-1:0] i_o,
  input  logic signed [WIDTH-1:0] i_c,
  input  logic signed [WIDTH-1:0] i_h,
  output logic signed [WIDTH-1:0] o_prev_state,
  output logic signed [WIDTH-1:0] o_prev_h,
  input  logic                    i_rd_start,
  input  logic                    i_rd_en,
  output logic                    o_rd_valid,
  output logic signed [WIDTH-1:0] o_rd_a,
  output logic signed [WIDTH-1:0] o_rd_i,
  output logic signed [WIDTH-1:0] o_rd_f,
  output logic signed [WIDTH-1:0] o_rd_o,
  output logic signed [WIDTH-1:0] o_rd_c,
  output logic signed [WIDTH-1:0] o_rd_h,
  output logic signed [WIDTH-1:0] o_rd_cprev,
  output logic                    o_rd_last,
  output logic [ADDR:0]           o_count,
  output logic                    o_full,
  output logic                    o_empty,
  output logic                    o_ovf
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR != $clog2(DEPTH) ||
      FRAC >= WIDTH) begin : g_param_check
    $error("lstm_state_buf: inconsistent WIDTH/FRAC/DEPTH/ADDR parameters");
  end

  localparam logic [ADDR:0] FULL_COUNT = (ADDR+1)'(DEPTH);

  state_t                    state;
  logic [ADDR:0]             count;
  logic [ADDR:0]             count_next;
  logic [ADDR-1:0]           wr_ptr;
  logic [ADDR-1:0]           rd_ptr;
  logic                      wr_accept;
  logic                      rd_beat;
  logic [N_FIELDS*WIDTH-1:0] rd_word;
  logic [WIDTH-1:0]          tap_c;

  assign o_count = count;
  assign o_full  = (count == FULL_COUNT);
  assign o_empty = (count == '0);

  // NOTE: every signal driven here gets a value on every path, so no latch forms.
  always_comb begin
    wr_accept  = rst && !i_clear && (state == FWD) && i_wr_en && !o_full;
    rd_beat    = rst && !i_clear && (state == BWD) && i_rd_en;
    count_next = count + {{ADDR{1'b0}}, wr_accept};
  end

  ts_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR  (ADDR)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_accept),
    .wr_addr  (wr_ptr),
    .wr_data  ({i_a, i_i, i_f, i_o, i_c, i_h}),
    .rd_en    (rd_beat),
    .rd_addr  (rd_ptr),
    .rd_data  (rd_word),
    .tap_addr (rd_ptr - ADDR'(1)),
    .tap_c    (tap_c)
  );

  assign {o_rd_a, o_rd_i, o_rd_f, o_rd_o, o_rd_c, o_rd_h} = rd_word;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= FWD;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_prev_state <= '0;
      o_prev_h     <= '0;
      o_rd_valid   <= 1'b0;
      o_rd_cprev   <= '0;
      o_rd_last    <= 1'b0;
      o_ovf        <= 1'b0;
    end else if (i_clear) begin
      state        <= FWD;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_prev_state <= '0;
      o_prev_h     <= '0;
      o_rd_valid   <= 1'b0;
      o_ovf        <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      unique case (state)
        FWD: begin
          if (wr_accept) begin
            wr_ptr       <= wr_ptr + ADDR'(1);
            count        <= count_next;
            o_prev_state <= i_c;
            o_prev_h     <= i_h;
          end else if (i_wr_en) begin
            o_ovf <= 1'b1;
          end
          // A same-cycle write is included in the replay.
          if (i_rd_start && count_next != '0) begin
            state  <= BWD;
            rd_ptr <= count_next[ADDR-1:0] - ADDR'(1);
          end
        end
        BWD: begin
          if (rd_beat) begin
            o_rd_valid <= 1'b1;
            o_rd_cprev <= (rd_ptr == '0) ? '0 : tap_c;
            o_rd_last  <= (rd_ptr == '0);
            if (rd_ptr == '0) state <= DONE;
            else              rd_ptr <= rd_ptr - ADDR'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_state_buf.sv
// Self-checking bench for lstm_state_buf: directed scenarios followed by random
// traffic, all compared against a queue-based reference model every cycle.
module tb_lstm_state_buf;

  localparam int W = 24;
  localparam int D = 8;
  localparam int A = 3;

  localparam int M_FWD  = 0;
  localparam int M_BWD  = 1;
  localparam int M_DONE = 2;

  typedef struct {
    logic signed [W-1:0] a, i, f, o, c, h;
  } ent_t;

  logic clk;
  logic rst, i_clear, i_wr_en, i_rd_start, i_rd_en;
  logic signed [W-1:0] i_a, i_i, i_f, i_o, i_c, i_h;
  logic signed [W-1:0] o_prev_state, o_prev_h;
  logic o_rd_valid, o_rd_last, o_full, o_empty, o_ovf;
  logic signed [W-1:0] o_rd_a, o_rd_i, o_rd_f, o_rd_o, o_rd_c, o_rd_h, o_rd_cprev;
  logic [A:0] o_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  ent_t ref_q[$];
  int   ref_mode;
  int   ref_next;
  logic signed [W-1:0] ref_prev_c, ref_prev_h, ref_cprev;
  logic ref_valid, ref_last, ref_ovf;
  ent_t ref_rd;

  lstm_state_buf dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_wr_en      (i_wr_en),
    .i_a          (i_a),
    .i_i          (i_i),
    .i_f          (i_f),
    .i_o          (i_o),
    .i_c          (i_c),
    .i_h          (i_h),
    .o_prev_state (o_prev_state),
    .o_prev_h     (o_prev_h),
    .i_rd_start   (i_rd_start),
    .i_rd_en      (i_rd_en),
    .o_rd_valid   (o_rd_valid),
    .o_rd_a       (o_rd_a),
    .o_rd_i       (o_rd_i),
    .o_rd_f       (o_rd_f),
    .o_rd_o       (o_rd_o),
    .o_rd_c       (o_rd_c),
    .o_rd_h       (o_rd_h),
    .o_rd_cprev   (o_rd_cprev),
    .o_rd_last    (o_rd_last),
    .o_count      (o_count),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_ovf        (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Advance the reference model by one clock using the current inputs.
  task automatic model_step();
    ent_t cur;
    cur.a = i_a; cur.i = i_i; cur.f = i_f; cur.o = i_o; cur.c = i_c; cur.h = i_h;
    if (!rst) begin
      ref_q.delete();
      ref_mode = M_FWD; ref_next = 0;
      ref_prev_c = 0; ref_prev_h = 0; ref_ovf = 0;
      ref_valid = 0; ref_last = 0; ref_cprev = 0;
      ref_rd = '{default: 0};
    end else if (i_clear) begin
      ref_q.delete();
      ref_mode = M_FWD;
      ref_prev_c = 0; ref_prev_h = 0; ref_ovf = 0; ref_valid = 0;
    end else begin
      ref_valid = 0;
      if (ref_mode == M_FWD) begin
        if (i_wr_en) begin
          if (ref_q.size() < D) begin
            ref_q.push_back(cur);
            ref_prev_c = i_c; ref_prev_h = i_h;
          end else begin
            ref_ovf = 1;
          end
        end
        if (i_rd_start && ref_q.size() > 0) begin
          ref_mode = M_BWD;
          ref_next = ref_q.size() - 1;
        end
      end else if (ref_mode == M_BWD && i_rd_en) begin
        ref_valid = 1;
        ref_rd    = ref_q[ref_next];
        ref_cprev = (ref_next == 0) ? '0 : ref_q[ref_next-1].c;
        ref_last  = (ref_next == 0);
        if (ref_next == 0) ref_mode = M_DONE;
        else               ref_next--;
      end
    end
  endtask

  task automatic check_all();
    check("count",   64'(o_count), 64'(ref_q.size()));
    check("empty",   64'(o_empty), 64'(ref_q.size() == 0));
    check("full",    64'(o_full),  64'(ref_q.size() == D));
    check("ovf",     64'(o_ovf),   64'(ref_ovf));
    check("prev_c",  o_prev_state, ref_prev_c);
    check("prev_h",  o_prev_h,     ref_prev_h);
    check("rd_valid", 64'(o_rd_valid), 64'(ref_valid));
    check("rd_a",    o_rd_a, ref_rd.a);
    check("rd_i",    o_rd_i, ref_rd.i);
    check("rd_f",    o_rd_f, ref_rd.f);
    check("rd_o",    o_rd_o, ref_rd.o);
    check("rd_c",    o_rd_c, ref_rd.c);
    check("rd_h",    o_rd_h, ref_rd.h);
    check("rd_cprev", o_rd_cprev, ref_cprev);
    if (ref_valid) check("rd_last", 64'(o_rd_last), 64'(ref_last));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit clr, input bit wr, input bit start, input bit rden);
    i_clear = clr; i_wr_en = wr; i_rd_start = start; i_rd_en = rden;
    i_a = W'($urandom); i_i = W'($urandom); i_f = W'($urandom);
    i_o = W'($urandom); i_c = W'($urandom); i_h = W'($urandom);
  endtask

  task automatic write_ch(input logic signed [W-1:0] c, input logic signed [W-1:0] h,
                          input bit start);
    drive(0, 1, start, 0);
    i_c = c; i_h = h;
    cycle();
  endtask

  task automatic ctl(input bit clr, input bit wr, input bit start, input bit rden);
    drive(clr, wr, start, rden);
    cycle();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b1;

    // Feedback latency
    write_ch(24'h040000, 24'h0C0000, 0);
    check("fb_prev_state", o_prev_state, 24'h040000);
    check("fb_prev_h",     o_prev_h,     24'h0C0000);

    // Reverse replay of three steps, then DONE ignores rd_en
    ctl(1, 0, 0, 0);
    for (int k = 1; k <= 3; k++) write_ch(W'(k << 20), W'($urandom), 0);
    ctl(0, 0, 1, 0);
    for (int k = 3; k >= 1; k--) begin
      ctl(0, 0, 0, 1);
      check("replay_c",     o_rd_c,     W'(k << 20));
      check("replay_cprev", o_rd_cprev, W'((k - 1) << 20));
      check("replay_last",  64'(o_rd_last), 64'(k == 1));
    end
    ctl(0, 1, 0, 1);
    check("done_no_beat", 64'(o_rd_valid), 64'(0));

    // Overflow: nine writes into eight entries, then replay everything
    ctl(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) ctl(0, 1, 0, 0);
    check("ovf_full",  64'(o_full), 64'(1));
    check("ovf_count", 64'(o_count), 64'(8));
    ctl(0, 0, 1, 0);
    for (int k = 0; k < 9; k++) ctl(0, 0, 0, 1);

    // Write together with rd_start at count 2
    ctl(1, 0, 0, 0);
    ctl(0, 1, 0, 0);
    ctl(0, 1, 0, 0);
    ctl(0, 1, 1, 0);
    for (int k = 0; k < 3; k++) ctl(0, 0, 0, 1);

    // Clear wins over a simultaneous write
    ctl(0, 1, 0, 0);
    ctl(1, 1, 0, 0);
    check("clear_wr_count", 64'(o_count), 64'(0));

    // Clear in the middle of a replay
    for (int k = 0; k < 4; k++) ctl(0, 1, 0, 0);
    ctl(0, 0, 1, 0);
    ctl(0, 0, 0, 1);
    ctl(1, 0, 0, 1);
    check("mid_clear_valid", 64'(o_rd_valid), 64'(0));
    ctl(0, 1, 0, 0);
    check("mid_clear_count", 64'(o_count), 64'(1));

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      cycle();
    end

    // Reset after traffic
    rst = 1'b0;
    drive(0, 1, 1, 1);
    cycle();
    cycle();
    check("reset_count", 64'(o_count), 64'(0));
    check("reset_empty", 64'(o_empty), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
